// File: rtl/cpu_debug_ctrl.sv
// Run-control responder for the core debug port: halt/run/step, breakpoint capture, retire counter.
// Define DBG_CYCLE_COUNT_EN to build the non-halted cycle counter read by READ_CYCLES.
module cpu_debug_ctrl #(
  parameter bit          HALT_ON_RESET = 1'b1,
  parameter int unsigned STEP_W        = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              halt,
  input  logic              breakpoint_fired,
  input  logic              instruction_retired
);

  localparam logic [1:0] StHalted   = 2'd0;
  localparam logic [1:0] StRunning  = 2'd1;
  localparam logic [1:0] StStepping = 2'd2;
  localparam logic [1:0] StBpHalted = 2'd3;

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpHalt    = 3'b001;
  localparam logic [2:0] OpRun     = 3'b010;
  localparam logic [2:0] OpStep    = 3'b011;
  localparam logic [2:0] OpClrBp   = 3'b100;
  localparam logic [2:0] OpReadRet = 3'b101;
  localparam logic [2:0] OpReadCyc = 3'b110;
  localparam logic [2:0] OpBad     = 3'b111;

  logic [1:0]        state_q, state_d;
  logic              halt_q, halt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              bp_sticky_q, bp_sticky_d;
  logic              bp_mask_q, bp_mask_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [31:0]       cycles_rd;
  logic              accept, retire, bp_hit, err, rd_ret, rd_cyc, cyc_ok;

`ifdef DBG_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles_q, cycles_d;
  assign cycles_d  = cycles_q + CNT_W'(!halt_q);
  assign cycles_rd = 32'(cycles_d);
  assign cyc_ok    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end
`else
  assign cycles_rd = 32'd0;
  assign cyc_ok    = 1'b0;
`endif

  assign cmd_ready = !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign halt      = halt_q;

  always_comb begin
    accept      = cmd_valid && cmd_ready;
    retire      = instruction_retired && !halt_q;
    bp_hit      = breakpoint_fired && !halt_q && !bp_mask_q &&
                  (state_q == StRunning || state_q == StStepping);
    state_d     = state_q;
    steps_d     = steps_q;
    bp_sticky_d = bp_sticky_q;
    bp_mask_d   = 1'b0;
    retired_d   = retired_q + CNT_W'(retire);
    err         = 1'b0;
    rd_ret      = 1'b0;
    rd_cyc      = 1'b0;

    // Lowest priority first so later assignments override.
    if (state_q == StStepping && retire) begin
      steps_d = steps_q - 1'b1;
      if (steps_q == STEP_W'(1)) state_d = StHalted;
    end
    if (bp_hit) begin
      state_d     = StBpHalted;
      bp_sticky_d = 1'b1;
      steps_d     = '0;
    end
    if (accept) begin
      unique case (cmd_op)
        OpNop: ;
        OpHalt: begin
          state_d = StHalted;
          steps_d = '0;
        end
        OpRun: begin
          if (state_q == StStepping) begin
            err = 1'b1;
          end else if (state_q != StRunning) begin
            state_d   = StRunning;
            steps_d   = '0;
            bp_mask_d = (state_q == StBpHalted);
          end
        end
        OpStep: begin
          if (state_q == StHalted || state_q == StBpHalted) begin
            state_d   = StStepping;
            steps_d   = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
            bp_mask_d = (state_q == StBpHalted);
          end else begin
            err = 1'b1;
          end
        end
        OpClrBp:   bp_sticky_d = bp_hit;
        OpReadRet: rd_ret = 1'b1;
        OpReadCyc: begin
          rd_cyc = cyc_ok;
          err    = !cyc_ok;
        end
        OpBad:     err = 1'b1;
        default: ;
      endcase
    end

    halt_d = (state_d == StHalted) || (state_d == StBpHalted);

    if (rd_ret) begin
      rsp_data_d = 32'(retired_d);
    end else if (rd_cyc) begin
      rsp_data_d = cycles_rd;
    end else if (err && cmd_op == OpReadCyc) begin
      rsp_data_d = 32'h0000_0010;
    end else begin
      rsp_data_d = {16'(steps_d), 11'd0, err, bp_sticky_d, state_d == StStepping,
                    state_d == StRunning, halt_d};
    end

    if (accept)         rsp_valid_d = 1'b1;
    else if (rsp_ready) rsp_valid_d = 1'b0;
    else                rsp_valid_d = rsp_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HALT_ON_RESET ? StHalted : StRunning;
      halt_q      <= HALT_ON_RESET;
      steps_q     <= '0;
      bp_sticky_q <= 1'b0;
      bp_mask_q   <= 1'b0;
      retired_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      steps_q     <= steps_d;
      bp_sticky_q <= bp_sticky_d;
      bp_mask_q   <= bp_mask_d;
      retired_q   <= retired_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl; expected responses queued at issue, compared on delivery.
module tb_cpu_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        halt;
  logic        breakpoint_fired = 1'b0;
  logic        instruction_retired = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  cpu_debug_ctrl #(
    .HALT_ON_RESET(1'b1),
    .STEP_W       (16),
    .CNT_W        (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_arg            (cmd_arg),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .halt               (halt),
    .breakpoint_fired   (breakpoint_fired),
    .instruction_retired(instruction_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command, check the response on the accepting edge, then consume it.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] arg, input logic [31:0] exp,
                        input string tag, input int hold);
    logic [31:0] got;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    got = rsp_valid ? rsp_data : 32'hDEAD_BEEF;
    check(tag, got, sb.pop_front());
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_free"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_halt", 32'(halt), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // 1: NOP status while halted, response held for two extra cycles
    do_cmd(3'b000, 16'd0, 32'h0000_0001, "nop_reset", 2);

    // 2: step three, halt lands on the third retirement
    do_cmd(3'b011, 16'd3, 32'h0003_0004, "step3", 0);
    @(negedge clk);
    instruction_retired = 1'b1;
    @(posedge clk); #1 check("step3_h1", 32'(halt), 32'd0);
    @(posedge clk); #1 check("step3_h2", 32'(halt), 32'd0);
    @(posedge clk); #1 check("step3_h3", 32'(halt), 32'd1);
    // retire held high while halted must not count
    do_cmd(3'b101, 16'd0, 32'd3, "read_ret3", 0);
    do_cmd(3'b000, 16'd0, 32'h0000_0001, "nop_after_step", 0);
    instruction_retired = 1'b0;

    // 3: breakpoint capture and one-cycle mask after resuming
    do_cmd(3'b010, 16'd0, 32'h0000_0002, "run1", 0);
    check("run1_halt", 32'(halt), 32'd0);
    @(negedge clk);
    breakpoint_fired = 1'b1;
    @(posedge clk); #1 check("bp_halt", 32'(halt), 32'd1);
    do_cmd(3'b000, 16'd0, 32'h0000_0009, "bp_status", 0);
    do_cmd(3'b010, 16'd0, 32'h0000_000A, "run_from_bp", 0);
    check("bp_masked", 32'(halt), 32'd0);
    @(posedge clk); #1 check("bp_retrigger", 32'(halt), 32'd1);
    breakpoint_fired = 1'b0;
    do_cmd(3'b100, 16'd0, 32'h0000_0001, "clr_bp", 0);

    // 4: step with arg 0 is one instruction; step while running is rejected
    do_cmd(3'b011, 16'd0, 32'h0001_0004, "step0", 0);
    @(negedge clk);
    instruction_retired = 1'b1;
    @(posedge clk); #1 check("step0_halt", 32'(halt), 32'd1);
    @(negedge clk);
    instruction_retired = 1'b0;
    do_cmd(3'b101, 16'd0, 32'd4, "read_ret4", 0);
    do_cmd(3'b010, 16'd0, 32'h0000_0002, "run2", 0);
    do_cmd(3'b011, 16'd5, 32'h0000_0012, "step_err", 0);
    do_cmd(3'b001, 16'd0, 32'h0000_0001, "halt2", 0);

    // 5: 4-bit retire counter wraps 15 -> 0
    do_cmd(3'b010, 16'd0, 32'h0000_0002, "run3", 0);
    @(negedge clk);
    instruction_retired = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    instruction_retired = 1'b0;
    do_cmd(3'b001, 16'd0, 32'h0000_0001, "halt3", 0);
    do_cmd(3'b101, 16'd0, 32'd15, "read_ret15", 0);
    do_cmd(3'b010, 16'd0, 32'h0000_0002, "run4", 0);
    @(negedge clk);
    instruction_retired = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instruction_retired = 1'b0;
    do_cmd(3'b001, 16'd0, 32'h0000_0001, "halt4", 0);
    do_cmd(3'b101, 16'd0, 32'd0, "read_ret_wrap", 0);

    // reset mid-step with a response pending discards everything
    do_cmd(3'b011, 16'd100, 32'h0064_0004, "step100", 0);
    @(negedge clk);
    instruction_retired = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'b000;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    instruction_retired = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_halt", 32'(halt), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(3'b000, 16'd0, 32'h0000_0001, "nop_after_rst", 0);
    do_cmd(3'b101, 16'd0, 32'd0, "read_ret_rst", 0);

    // 6: cycle counter read
`ifdef DBG_CYCLE_COUNT_EN
    do_cmd(3'b010, 16'd0, 32'h0000_0002, "run_cyc", 0);
    repeat (8) @(posedge clk);
    do_cmd(3'b001, 16'd0, 32'h0000_0001, "halt_cyc", 0);
    do_cmd(3'b110, 16'd0, 32'd10, "read_cycles", 0);
`else
    do_cmd(3'b110, 16'd0, 32'h0000_0010, "read_cycles_off", 0);
`endif
    do_cmd(3'b111, 16'd0, 32'h0000_0011, "bad_op", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
